// File: rtl/hpe_param.sv
// rtl/hpe_param.sv - parametrised output-stationary systolic PE with valid/ready result register
// Optional build macro HPE_PARAM_SAT_EN saturates the value loaded into C instead of truncating it.
module hpe_param #(
    parameter int DW    = 8,
    parameter int K_MAX = 8,
    parameter int OUT_W = 19,
    localparam int ACC_W = 2*DW + $clog2(K_MAX),
    localparam int KW    = $clog2(K_MAX+1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIGNED_MODE,
    input  logic [KW-1:0]    K_LEN,
    input  logic [DW-1:0]    A,
    input  logic [DW-1:0]    B,
    input  logic             A_valid_in,
    input  logic             B_valid_in,
    output logic [DW-1:0]    A_out,
    output logic [DW-1:0]    B_out,
    output logic             A_valid_out,
    output logic             B_valid_out,
    output logic [OUT_W-1:0] C,
    output logic             C_valid_out,
    input  logic             C_ready_in,
    output logic             C_overrun
);

    logic             acc_en;
    logic             first;
    logic             last;
    logic             cur_sign;
    logic             sign_q;
    logic [KW-1:0]    k_cnt;
    logic [KW-1:0]    k_len_q;
    logic [KW-1:0]    k_clamp;
    logic [KW-1:0]    cur_len;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;
    logic [OUT_W-1:0] c_next;

    // On the first element the mode and length come straight from the ports, later from the latches.
    always_comb begin
        acc_en = A_valid_out && B_valid_out;
        first  = (k_cnt == '0);
        if (K_LEN == '0)
            k_clamp = KW'(1);
        else if (K_LEN > KW'(K_MAX))
            k_clamp = KW'(K_MAX);
        else
            k_clamp = K_LEN;
        cur_sign = first ? SIGNED_MODE : sign_q;
        cur_len  = first ? k_clamp : k_len_q;
        a_ext = cur_sign ? {{(ACC_W-DW){A_out[DW-1]}}, A_out} : {{(ACC_W-DW){1'b0}}, A_out};
        b_ext = cur_sign ? {{(ACC_W-DW){B_out[DW-1]}}, B_out} : {{(ACC_W-DW){1'b0}}, B_out};
        prod  = a_ext * b_ext;
        sum   = first ? prod : acc + prod;
        last  = acc_en && (k_cnt == cur_len - KW'(1));
    end

`ifdef HPE_PARAM_SAT_EN
    localparam logic [ACC_W-1:0] UMAX = (ACC_W'(1) << OUT_W) - ACC_W'(1);
    localparam logic [ACC_W-1:0] SMAX = (ACC_W'(1) << (OUT_W-1)) - ACC_W'(1);
    localparam logic [ACC_W-1:0] SMIN = ~SMAX;

    always_comb begin
        c_next = OUT_W'(sum);
        if (cur_sign) begin
            if ($signed(sum) > $signed(SMAX))
                c_next = OUT_W'(SMAX);
            else if ($signed(sum) < $signed(SMIN))
                c_next = OUT_W'(SMIN);
        end else if (sum > UMAX) begin
            c_next = OUT_W'(UMAX);
        end
    end
`else
    assign c_next = OUT_W'(sum);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            A_out       <= '0;
            B_out       <= '0;
            A_valid_out <= 1'b0;
            B_valid_out <= 1'b0;
            k_cnt       <= '0;
            k_len_q     <= '0;
            sign_q      <= 1'b0;
            acc         <= '0;
            C           <= '0;
            C_valid_out <= 1'b0;
            C_overrun   <= 1'b0;
        end else if (EN) begin
            A_out       <= A;
            B_out       <= B;
            A_valid_out <= A_valid_in;
            B_valid_out <= B_valid_in;
            if (acc_en) begin
                acc   <= sum;
                k_cnt <= last ? '0 : k_cnt + KW'(1);
                if (first) begin
                    k_len_q <= k_clamp;
                    sign_q  <= SIGNED_MODE;
                end
            end
            // A completing result wins over a handshake; it only counts as overrun if the old one was not taken.
            if (last) begin
                C           <= c_next;
                C_valid_out <= 1'b1;
                if (C_valid_out && !C_ready_in)
                    C_overrun <= 1'b1;
            end else if (C_valid_out && C_ready_in) begin
                C_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hpe_param.sv
// tb/tb_hpe_param.sv - directed plus randomized bench for hpe_param against an arithmetic dot-product model
module tb_hpe_param;

`ifdef HPE_PARAM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b1;
    logic        SIGNED_MODE = 1'b0;
    logic [3:0]  K_LEN = 4'd8;
    logic [7:0]  A = 8'h5A;
    logic [7:0]  B = 8'hA5;
    logic        A_valid_in = 1'b1;
    logic        B_valid_in = 1'b1;
    logic        C_ready_in = 1'b1;

    logic [7:0]  A_out, B_out, A_out16, B_out16;
    logic        A_valid_out, B_valid_out, A_valid_out16, B_valid_out16;
    logic [18:0] C;
    logic [15:0] C16;
    logic        C_valid_out, C_overrun, C_valid_out16, C_overrun16;

    int n_vec = 0;
    int n_err = 0;
    int ga[16];
    int gb[16];
    int lat;

    hpe_param u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SIGNED_MODE(SIGNED_MODE), .K_LEN(K_LEN),
        .A(A), .B(B), .A_valid_in(A_valid_in), .B_valid_in(B_valid_in),
        .A_out(A_out), .B_out(B_out), .A_valid_out(A_valid_out), .B_valid_out(B_valid_out),
        .C(C), .C_valid_out(C_valid_out), .C_ready_in(C_ready_in), .C_overrun(C_overrun)
    );

    hpe_param #(.OUT_W(16)) u_dut16 (
        .CLK(CLK), .RST(RST), .EN(EN), .SIGNED_MODE(SIGNED_MODE), .K_LEN(K_LEN),
        .A(A), .B(B), .A_valid_in(A_valid_in), .B_valid_in(B_valid_in),
        .A_out(A_out16), .B_out(B_out16), .A_valid_out(A_valid_out16), .B_valid_out(B_valid_out16),
        .C(C16), .C_valid_out(C_valid_out16), .C_ready_in(C_ready_in), .C_overrun(C_overrun16)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    function automatic logic [31:0] fold(input longint s_in, input int w, input bit sgn);
        longint s, hi, lo;
        s = s_in;
        if (SAT) begin
            if (sgn) begin
                hi = (longint'(1) << (w-1)) - 1;
                lo = -(longint'(1) << (w-1));
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end else begin
                hi = (longint'(1) << w) - 1;
                if (s > hi) s = hi;
            end
        end
        return 32'(s & ((longint'(1) << w) - 1));
    endfunction

    task automatic drive_pair(input int a, input int b);
        A = 8'(a);
        B = 8'(b);
        A_valid_in = 1'b1;
        B_valid_in = 1'b1;
        tick();
        chk("a_fwd", 32'(A_out), 32'(a));
        chk("b_fwd", 32'(B_out), 32'(b));
    endtask

    task automatic idle(input int n);
        A_valid_in = 1'b0;
        B_valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_c(input string tag, input logic [31:0] e19, input logic [31:0] e16, output int t);
        A_valid_in = 1'b0;
        B_valid_in = 1'b0;
        t = 0;
        while (C_valid_out !== 1'b1 && t < 12) begin
            tick();
            t++;
        end
        chk({tag, "_valid"}, 32'(C_valid_out), 32'd1);
        chk({tag, "_c"}, 32'(C), e19);
        chk({tag, "_c16"}, 32'(C16), e16);
    endtask

    // Operands come from ga/gb; mid-dot K_LEN and SIGNED_MODE are scrambled and must be ignored.
    task automatic run_dot(input string tag, input int klen, input bit sgn, output int t);
        int     n;
        longint s;
        n = (klen == 0) ? 1 : ((klen > 8) ? 8 : klen);
        s = 0;
        for (int i = 0; i < n; i++)
            s += sgn ? longint'(sx(ga[i])) * sx(gb[i]) : longint'(ga[i]) * gb[i];
        K_LEN = 4'(klen);
        SIGNED_MODE = sgn;
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                K_LEN = 4'($urandom_range(0, 15));
                SIGNED_MODE = ~sgn;
            end
            drive_pair(ga[i], gb[i]);
        end
        wait_c(tag, fold(s, 19, sgn), fold(s, 16, sgn), t);
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < 16; i++) begin
            ga[i] = a;
            gb[i] = b;
        end
    endtask

    initial begin
        // Reset with busy inputs
        tick();
        tick();
        chk("rst_a_out", 32'(A_out), 32'd0);
        chk("rst_avalid", 32'(A_valid_out), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_cvalid", 32'(C_valid_out), 32'd0);
        chk("rst_ovr", 32'(C_overrun), 32'd0);
        A_valid_in = 1'b0;
        B_valid_in = 1'b0;
        RST = 1'b1;
        tick();

        fill(3, 5);
        run_dot("k8_3x5", 8, 1'b0, lat);
        chk("k8_latency", 32'(lat), 32'd1);
        tick();
        chk("k8_one_cycle", 32'(C_valid_out), 32'd0);

        fill(8'hFE, 8'h03);
        run_dot("signed", 4, 1'b1, lat);
        run_dot("unsigned", 4, 1'b0, lat);

        fill(1, 1);
        run_dot("klen0", 0, 1'b0, lat);
        run_dot("klen9", 9, 1'b0, lat);

        fill(8'hFF, 8'hFF);
        run_dot("ff_sat", 8, 1'b0, lat);

        // Valid gap mid-dot
        K_LEN = 4'd8;
        SIGNED_MODE = 1'b0;
        for (int i = 0; i < 4; i++) drive_pair(2, 2);
        idle(3);
        for (int i = 0; i < 4; i++) drive_pair(2, 2);
        wait_c("gap", 32'd32, 32'd32, lat);

        // Reset discards a partial dot
        for (int i = 0; i < 5; i++) drive_pair(1, 1);
        RST = 1'b0;
        idle(1);
        chk("mid_rst_avalid", 32'(A_valid_out), 32'd0);
        RST = 1'b1;
        fill(1, 1);
        run_dot("post_rst", 8, 1'b0, lat);
        chk("post_rst_ovr", 32'(C_overrun), 32'd0);

        for (int r = 0; r < 20; r++) begin
            int klen;
            bit sgn;
            klen = $urandom_range(0, 12);
            sgn = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                ga[i] = $urandom_range(0, 255);
                gb[i] = $urandom_range(0, 255);
            end
            run_dot("rand", klen, sgn, lat);
            idle(1);
        end

        // Back-to-back K=2 dots without acceptance
        idle(2);
        K_LEN = 4'd2;
        SIGNED_MODE = 1'b0;
        C_ready_in = 1'b0;
        drive_pair(1, 1);
        drive_pair(1, 1);
        drive_pair(2, 2);
        chk("ovr_first_c", 32'(C), 32'd2);
        chk("ovr_first_v", 32'(C_valid_out), 32'd1);
        chk("ovr_first_flag", 32'(C_overrun), 32'd0);
        drive_pair(2, 2);
        idle(1);
        chk("ovr_second_c", 32'(C), 32'd8);
        chk("ovr_flag", 32'(C_overrun), 32'd1);
        idle(2);
        chk("ovr_sticky", 32'(C_overrun), 32'd1);

        // Same, but collector accepts on the completion edge
        RST = 1'b0;
        idle(1);
        chk("ovr_rst", 32'(C_overrun), 32'd0);
        RST = 1'b1;
        drive_pair(1, 1);
        drive_pair(1, 1);
        drive_pair(2, 2);
        chk("nov_first_c", 32'(C), 32'd2);
        drive_pair(2, 2);
        C_ready_in = 1'b1;
        idle(1);
        chk("nov_second_c", 32'(C), 32'd8);
        chk("nov_valid", 32'(C_valid_out), 32'd1);
        chk("nov_flag", 32'(C_overrun), 32'd0);
        idle(1);
        chk("nov_drained", 32'(C_valid_out), 32'd0);

        // EN=0 freezes state and blocks the handshake
        C_ready_in = 1'b0;
        fill(3, 3);
        run_dot("en_dot", 1, 1'b0, lat);
        EN = 1'b0;
        C_ready_in = 1'b1;
        A = 8'd7;
        idle(1);
        chk("en0_cvalid", 32'(C_valid_out), 32'd1);
        chk("en0_a_hold", 32'(A_out), 32'd3);
        EN = 1'b1;
        idle(1);
        chk("en1_cvalid", 32'(C_valid_out), 32'd0);
        chk("en1_a_fwd", 32'(A_out), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
